// File: rtl/board_pkg.sv
`timescale 1ns/1ps
// Board-level constants shared by the key/LED bring-up block.
package board_pkg;
  localparam int   KEY_W        = 4;
  localparam int   SYS_CLK_HZ   = 200_000_000;
  localparam logic LED_OFF      = 1'b1;
  localparam logic KEY_RELEASED = 1'b1;
endpackage

// File: rtl/key_led_test_if.sv
`timescale 1ns/1ps
// Key/LED bundle: board drives keys in, block drives LEDs out.
// Both are active-low: key 0 = pressed, led 0 = lit.
interface key_led_test_if #(
  parameter int KEY_W = board_pkg::KEY_W
);
  logic [KEY_W-1:0] key;
  logic [KEY_W-1:0] led;

  modport master (output key, input led);
  modport slave  (input key, output led);
endinterface

// File: rtl/clk_diff_buf.sv
`timescale 1ns/1ps
// Differential clock input buffer. On the board this is the vendor IBUFDS.
// The body here is the behavioural equivalent used for simulation and lint:
// the output is high only while the positive leg is high and the negative
// leg is low.
module clk_diff_buf (
  input  logic i,
  input  logic ib,
  output logic o
);
  assign o = i & ~ib;
endmodule

// File: rtl/key_led_test.sv
`timescale 1ns/1ps
// Board bring-up: each push-button is synchronised into the buffered
// 200 MHz domain and mirrored onto its LED through an output register.
// Polarity passes straight through, so a pressed key (0) lights its LED (0).
// SYNC_STAGES must be 2 or more.
module key_led_test #(
  parameter int KEY_W       = board_pkg::KEY_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic           sys_clk_p,
  input  logic           sys_clk_n,
  input  logic           rst,
  key_led_test_if.slave  bus
);
  import board_pkg::*;

  logic clk_s;

  clk_diff_buf u_clk_buf (
    .i  (sys_clk_p),
    .ib (sys_clk_n),
    .o  (clk_s)
  );

  for (genvar i = 0; i < KEY_W; i++) begin : g_bit
    logic [SYNC_STAGES-1:0] chain_r;
    logic                   led_r;

    // Key synchroniser chain followed by the LED output register; reset parks everything at released/dark.
    always_ff @(posedge clk_s or posedge rst) begin
      if (rst) begin
        chain_r <= {SYNC_STAGES{KEY_RELEASED}};
        led_r   <= LED_OFF;
      end else begin
        chain_r <= {chain_r[SYNC_STAGES-2:0], bus.key[i]};
        led_r   <= chain_r[SYNC_STAGES-1];
      end
    end

    assign bus.led[i] = led_r;
  end
endmodule

// File: tb/tb_key_led_test.sv
`timescale 1ns/1ps
// Self-checking bench for key_led_test: reset, table-driven follow checks,
// hand-written corner sequences, and a randomized run against a delay-line
// reference model of "led = key as it stood SYNC_STAGES edges earlier".
module tb_key_led_test;
  localparam int W  = 4;
  localparam int SS = 2;

  logic sys_clk_p = 1'b0;
  logic sys_clk_n = 1'b1;
  logic rst       = 1'b0;

  key_led_test_if #(.KEY_W(W)) bus ();

  key_led_test #(.KEY_W(W), .SYNC_STAGES(SS)) dut (
    .sys_clk_p (sys_clk_p),
    .sys_clk_n (sys_clk_n),
    .rst       (rst),
    .bus       (bus)
  );

  // 200 MHz differential clock pair
  always #2.5 begin
    sys_clk_p = ~sys_clk_p;
    sys_clk_n = ~sys_clk_n;
  end

  int checks   = 0;
  int failures = 0;

  // Rising edges of the buffered clock
  int clk_edges = 0;
  always @(posedge dut.clk_s) clk_edges++;

  // Unknown-value watch on led once reset has been applied
  logic reset_seen = 1'b0;
  logic x_seen     = 1'b0;
  always @(negedge sys_clk_p) begin
    if (reset_seen && $isunknown(bus.led)) x_seen = 1'b1;
  end

  typedef struct {
    logic [W-1:0] key;
    logic [W-1:0] exp_mid;
    logic [W-1:0] exp_led;
  } vec_t;

  vec_t table_v[6];
  logic [W-1:0] dq[$];

  task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: led=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance past one rising edge and settle away from it
  task automatic step_edge();
    @(posedge sys_clk_p);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] prev;
    logic [W-1:0] exp;
    logic [W-1:0] nk;
    int ones;
    logic others_ok;
    int c0;

    table_v[0] = '{key: 4'b0101, exp_mid: 4'b1111, exp_led: 4'b0101};
    table_v[1] = '{key: 4'b1010, exp_mid: 4'b0101, exp_led: 4'b1010};
    table_v[2] = '{key: 4'b0000, exp_mid: 4'b1010, exp_led: 4'b0000};
    table_v[3] = '{key: 4'b1111, exp_mid: 4'b0000, exp_led: 4'b1111};
    table_v[4] = '{key: 4'b0011, exp_mid: 4'b1111, exp_led: 4'b0011};
    table_v[5] = '{key: 4'b1100, exp_mid: 4'b0011, exp_led: 4'b1100};

    // 1: reset
    bus.key = 4'b1111;
    #0.5;
    rst = 1'b1;
    reset_seen = 1'b1;
    #1;
    check_vec("reset_at_once", bus.led, 4'b1111);
    #16.5;
    check_vec("reset_hold", bus.led, 4'b1111);
    #2;
    rst = 1'b0;
    step_edge();
    check_vec("after_reset_release", bus.led, 4'b1111);

    // Table: latency is exactly SS+1 edges, previous value held until then
    for (int t = 0; t < 6; t++) begin
      bus.key = table_v[t].key;
      step_edge();
      step_edge();
      check_vec($sformatf("table%0d_mid", t), bus.led, table_v[t].exp_mid);
      step_edge();
      check_vec($sformatf("table%0d_final", t), bus.led, table_v[t].exp_led);
    end

    // 2: follow and hold 25 ns
    bus.key = 4'b0101;
    repeat (3) step_edge();
    check_vec("follow_0101", bus.led, 4'b0101);
    for (int h = 0; h < 5; h++) begin
      step_edge();
      check_vec($sformatf("hold_%0d", h), bus.led, 4'b0101);
    end

    // 3: all-bit toggle, no intermediate values
    prev = 4'b0101;
    bus.key = 4'b1010;
    for (int e = 0; e < 3; e++) begin
      step_edge();
      checks++;
      if (bus.led !== prev && bus.led !== 4'b1010) begin
        failures++;
        $display("FAIL toggle_intermediate: led=%b expected=%b or %b", bus.led, prev, 4'b1010);
      end
    end
    check_vec("toggle_final", bus.led, 4'b1010);

    // 4: short pulse on key[0]: 8 ns high then 16 ns low
    ones = 0;
    others_ok = 1'b1;
    bus.key[0] = 1'b1;
    #8;
    bus.key[0] = 1'b0;
    for (int e = 0; e < 6; e++) begin
      step_edge();
      if (bus.led[0] === 1'b1) ones++;
      if (bus.led[3:1] !== 3'b101) others_ok = 1'b0;
    end
    checks++;
    if (ones < 1) begin
      failures++;
      $display("FAIL pulse_seen: high_cycles=%0d expected at least 1", ones);
    end
    check_int("pulse_others_unchanged", int'(others_ok), 1);
    check_vec("pulse_final", bus.led, 4'b1010);

    // 5: mid-operation reset
    bus.key = 4'b0000;
    repeat (3) step_edge();
    check_vec("midrst_before", bus.led, 4'b0000);
    rst = 1'b1;
    #1;
    check_vec("midrst_async", bus.led, 4'b1111);
    step_edge();
    check_vec("midrst_held", bus.led, 4'b1111);
    rst = 1'b0;
    step_edge();
    step_edge();
    check_vec("midrst_release_2edges", bus.led, 4'b1111);
    step_edge();
    check_vec("midrst_release_3edges", bus.led, 4'b0000);

    // Randomized run against the delay-line model
    dq = {};
    repeat (SS) dq.push_back(4'b0000);
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(39, 0) == 0) begin
        rst = 1'b1;
        #1;
        check_vec("rand_reset_async", bus.led, 4'b1111);
        rst = 1'b0;
        dq = {};
        repeat (SS) dq.push_back(4'b1111);
      end
      if ($urandom_range(1, 0) == 1) begin
        nk = W'($urandom);
        bus.key = nk;
      end
      step_edge();
      exp = dq.pop_front();
      dq.push_back(bus.key);
      check_vec($sformatf("rand_%0d", n), bus.led, exp);
    end

    // 6: buffered clock runs at 200 MHz
    c0 = clk_edges;
    #100;
    check_int("clk_edges_100ns", clk_edges - c0, 20);
    check_int("led_never_x", int'(x_seen), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
